// File: rtl/sample_ping_pong_buffer.sv
// Two-bank ping-pong sample store: one bank fills while the other drains over valid/ready.
// Optional macro SAMPLE_BUF_DROP_CNT_EN enables the saturating 16-bit drop counter.
module sample_ping_pong_buffer #(
  parameter int BUFFER_DEPTH = 16,
  parameter int DATA_WIDTH   = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  output logic                  ram_buffer_ready_o,
  output logic [DATA_WIDTH-1:0] ram_read_data_o,
  output logic                  ram_read_valid_o,
  input  logic                  ram_read_ready_i,
  output logic                  overflow_o,
  output logic [15:0]           drop_count_o,
  output logic [5:0]            debug_o
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUFFER_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [2*BUFFER_DEPTH];

  logic          wr_bank_q, rd_bank_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [1:0]    full_q, full_d;
  logic          overflow_q;

  logic wr_accept, wr_drop, wr_last, rd_valid, rd_hs, rd_last;

  // Handshake: a word transfers on a cycle where ram_read_valid_o and ram_read_ready_i are both high;
  // while valid is high and ready low, data and valid are held unchanged.
  assign wr_accept = sample_valid_i & ~full_q[wr_bank_q];
  assign wr_drop   = sample_valid_i &  full_q[wr_bank_q];
  assign wr_last   = wr_accept & (wr_ptr_q == PTR_LAST);
  assign rd_valid  = full_q[rd_bank_q];
  assign rd_hs     = rd_valid & ram_read_ready_i;
  assign rd_last   = rd_hs & (rd_ptr_q == PTR_LAST);

  // Fill and drain in one cycle always hit different banks, so both updates apply.
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_accept) begin
        wr_ptr_q <= wr_last ? '0 : wr_ptr_q + PTR_ONE;
        if (wr_last) wr_bank_q <= ~wr_bank_q;
      end
      if (rd_hs) begin
        rd_ptr_q <= rd_last ? '0 : rd_ptr_q + PTR_ONE;
        if (rd_last) rd_bank_q <= ~rd_bank_q;
      end
      if (wr_drop) overflow_q <= 1'b1;
    end
  end

  // Storage is not reset; the full flags gate every read.
  always_ff @(posedge clk_i) begin
    if (wr_accept) mem[{wr_bank_q, wr_ptr_q}] <= sample_i;
  end

`ifdef SAMPLE_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (wr_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = '0;
`endif

  assign ram_buffer_ready_o = rd_valid;
  assign ram_read_valid_o   = rd_valid;
  assign ram_read_data_o    = rd_valid ? mem[{rd_bank_q, rd_ptr_q}] : '0;
  assign overflow_o         = overflow_q;
  assign debug_o            = {full_q[1], full_q[0], wr_bank_q, rd_bank_q, overflow_q, sample_valid_i};

endmodule

// File: tb/tb_sample_ping_pong_buffer.sv
// Bench for sample_ping_pong_buffer: directed scenarios plus random traffic checked
// against a queue-level model (completed banks as one FIFO of words, partial fill separate).
module tb_sample_ping_pong_buffer;
  localparam int DEPTH = 16;
  localparam int W     = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  sample = '0;
  logic          sample_valid = 1'b0;
  logic          buf_ready;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [5:0]    debug;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];   // words of completed banks not yet read, in order
  logic [W-1:0] fill_q[$];  // words of the bank currently being filled
  int unsigned  drops;
  bit           ovf;

  always #5 clk = ~clk;

  sample_ping_pong_buffer #(.BUFFER_DEPTH(DEPTH), .DATA_WIDTH(W)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .sample_i(sample),
    .sample_valid_i(sample_valid),
    .ram_buffer_ready_o(buf_ready),
    .ram_read_data_o(rd_data),
    .ram_read_valid_o(rd_valid),
    .ram_read_ready_i(rd_ready),
    .overflow_o(overflow),
    .drop_count_o(drop_count),
    .debug_o(debug)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_drop_count();
`ifdef SAMPLE_BUF_DROP_CNT_EN
    return (drops > 65535) ? 16'hFFFF : 16'(drops);
`else
    return 16'h0;
`endif
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    fill_q.delete();
    drops = 0;
    ovf   = 1'b0;
  endfunction

  task automatic compare_outputs();
    logic [W-1:0] exp_data;
    exp_data = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("valid",     {31'b0, rd_valid},  {31'b0, exp_q.size() > 0});
    check("buf_ready", {31'b0, buf_ready}, {31'b0, exp_q.size() > 0});
    check("data",      {8'b0, rd_data},    {8'b0, exp_data});
    check("overflow",  {31'b0, overflow},  {31'b0, ovf});
    check("drops",     {16'b0, drop_count}, {16'b0, exp_drop_count()});
    check("dbg_low",   {30'b0, debug[1:0]}, {30'b0, ovf, sample_valid});
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model past the next edge.
  task automatic step(input bit v, input logic [W-1:0] s, input bit r, input bit full_chk = 1'b1);
    int nfull;
    bit hs;
    @(negedge clk);
    sample_valid = v;
    sample       = s;
    rd_ready     = r;
    #1;
    if (full_chk) compare_outputs();
    nfull = (exp_q.size() + DEPTH - 1) / DEPTH;
    hs    = (exp_q.size() > 0) && r;
    if (v) begin
      if (nfull < 2) fill_q.push_back(s);
      else begin
        drops++;
        ovf = 1'b1;
      end
    end
    if (hs) void'(exp_q.pop_front());
    if (fill_q.size() == DEPTH) begin
      foreach (fill_q[i]) exp_q.push_back(fill_q[i]);
      fill_q.delete();
    end
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", {31'b0, rd_valid},   32'h0);
    check("rst_ready", {31'b0, buf_ready},  32'h0);
    check("rst_data",  {8'b0, rd_data},     32'h0);
    check("rst_ovf",   {31'b0, overflow},   32'h0);
    check("rst_drops", {16'b0, drop_count}, 32'h0);
    check("rst_dbg",   {26'b0, debug[5:1], 1'b0}, 32'h0);
    model_reset();
    sample_valid = 1'b0;
    rd_ready     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, '0, r);
  endtask

  logic [W-1:0] sign_vals [4];

  initial begin
    model_reset();
    sign_vals[0] = 24'hFFFFFF;
    sign_vals[1] = 24'h800000;
    sign_vals[2] = 24'h7FFFFF;
    sign_vals[3] = 24'h000001;
    #12;
    check("init_valid", {31'b0, rd_valid}, 32'h0);
    check("init_data",  {8'b0, rd_data},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill one bank with ready held high, then drain it.
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1);
    idle(20, 1'b1);

    // Overfill both banks and drop 8, then read everything back.
    for (int i = 1; i <= 40; i++) step(1'b1, W'(i), 1'b0);
    idle(34, 1'b1);

    // Backpressure with ready toggling every cycle.
    for (int i = 0; i < 64; i++) step(1'b1, W'(i), i[0]);
    for (int i = 0; i < 80; i++) step(1'b0, '0, i[0]);

    // Bit-exact passthrough of extreme values.
    for (int i = 0; i < 16; i++) step(1'b1, (i < 4) ? sign_vals[i] : '0, 1'b0);
    idle(20, 1'b1);

    // Reset during a partial fill, and again mid-drain.
    for (int i = 0; i < 7; i++) step(1'b1, W'(100 + i), 1'b0);
    async_reset();
    for (int i = 0; i < 16; i++) step(1'b1, W'(200 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    async_reset();
    for (int i = 0; i < 16; i++) step(1'b1, W'(300 + i), 1'b0);
    idle(20, 1'b1);

    // Sample coinciding with the final handshake that frees the write bank is dropped.
    for (int i = 0; i < 32; i++) step(1'b1, W'(400 + i), 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 24'hABCDEF, 1'b1);
    step(1'b1, 24'h123456, 1'b0);
    idle(40, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) < 60), W'($urandom), ($urandom_range(0, 99) < 45));
    idle(40, 1'b1);

    // Saturate the drop counter.
    async_reset();
    for (int i = 0; i < 32; i++) step(1'b1, W'($urandom), 1'b0);
    for (int i = 0; i < 66000; i++) step(1'b1, W'(i), 1'b0, (i % 1000) == 0);
    step(1'b0, '0, 1'b0);
    check("sat_drops", {16'b0, drop_count}, {16'b0, exp_drop_count()});
    check("sat_ovf",   {31'b0, overflow},   32'h1);
    idle(40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
